// File: rtl/cbus_ram_responder.sv
// cbus_ram_responder: word-addressed RAM behind a CBus device port.
// Serves one read or write burst of 1-16 beats at a time. The first beat
// arrives a fixed LATENCY after the request is seen. Addresses wrap modulo
// the RAM depth.

package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
        logic        okay;
    } cbus_resp_t;

endpackage

module cbus_ram_responder
    import cbus_pkg::*;
#(
    parameter int SIZE_WORDS = 1024,
    parameter int LATENCY    = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  req,
    output cbus_resp_t resp
);

    localparam int AW = $clog2(SIZE_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } state_t;

    state_t        state_q,   state_d;
    logic          isWrite_q, isWrite_d;
    logic [AW-1:0] base_q,    base_d;
    logic [3:0]    len_q,     len_d;
    logic [3:0]    beat_q,    beat_d;
    logic [3:0]    waitCnt_q, waitCnt_d;
    logic [63:0]   rdData_q,  rdData_d;

    logic [63:0]   mem [SIZE_WORDS];

    logic [AW-1:0] reqIdx;
    logic [AW-1:0] curIdx;
    logic [AW-1:0] nextIdx;
    logic          memWe;
    logic          unusedReqBits;

    // Word indices wrap by truncation, so high address bits simply alias.
    assign reqIdx        = req.addr[AW+2:3];
    assign curIdx        = base_q + AW'(beat_q);
    assign nextIdx       = curIdx + AW'(1);
    assign unusedReqBits = ^{req.size, req.addr[31:AW+3], req.addr[2:0]};

    // Next-state logic. The read word for the upcoming beat is fetched one
    // cycle early, so resp.data is a register that is valid during the beat.
    always_comb begin
        state_d   = state_q;
        isWrite_d = isWrite_q;
        base_d    = base_q;
        len_d     = len_q;
        beat_d    = beat_q;
        waitCnt_d = waitCnt_q;
        rdData_d  = '0;
        memWe     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req.valid) begin
                    isWrite_d = req.is_write;
                    base_d    = reqIdx;
                    len_d     = req.len;
                    beat_d    = '0;
                    waitCnt_d = 4'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                    end else begin
                        state_d  = BURST;
                        rdData_d = req.is_write ? 64'd0 : mem[reqIdx];
                    end
                end
            end

            WAIT: begin
                if (!req.valid) begin
                    state_d = IDLE;
                end else if (waitCnt_q <= 4'd1) begin
                    state_d  = BURST;
                    beat_d   = '0;
                    rdData_d = isWrite_q ? 64'd0 : mem[base_q];
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end

            BURST: begin
                if (!req.valid) begin
                    state_d = IDLE;
                end else begin
                    memWe = isWrite_q;
                    if (beat_q == len_q) begin
                        state_d = IDLE;
                    end else begin
                        beat_d   = beat_q + 4'd1;
                        rdData_d = isWrite_q ? 64'd0 : mem[nextIdx];
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Control state and response data. Reset drops any in-flight burst.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            isWrite_q <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            waitCnt_q <= '0;
            rdData_q  <= '0;
        end else begin
            state_q   <= state_d;
            isWrite_q <= isWrite_d;
            base_q    <= base_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            waitCnt_q <= waitCnt_d;
            rdData_q  <= rdData_d;
        end
    end

    // Byte-masked write of the current beat. The RAM has no reset, so its
    // contents survive a reset.
    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int i = 0; i < 8; i++) begin
                if (req.strobe[i]) begin
                    mem[curIdx][8*i +: 8] <= req.data[8*i +: 8];
                end
            end
        end
    end

    assign resp.ready = (state_q == BURST);
    assign resp.okay  = (state_q == BURST);
    assign resp.last  = (state_q == BURST) && (beat_q == len_q);
    assign resp.data  = rdData_q;

endmodule
